mdu_sequencer: RTL

Multi-cycle multiply/divide sequencer that owns the HI/LO special registers feeding the register-writeback source select. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs 32-iteration radix-2 shift-add / restoring-divide sequences. It stalls the pipeline when an instruction reads or writes HI/LO while an operation is in flight. It aborts cleanly on an exception/interrupt flush.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_step.sv | 52 +++++
 rtl/mdu_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide sequencer.
//   - op encodings presented by EX with start
//   - FSM state encoding
//   - iteration count and divide-by-zero quotient value
package mdu_pkg;

  localparam int MDU_DATA_BITS = 32;
  localparam int MDU_ITERS     = MDU_DATA_BITS;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mdu_mode_e;

  localparam logic [MDU_DATA_BITS-1:0] DIV0_LO = '1;

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration, purely combinational.
//   i_mode   : MODE_MUL shift-add, MODE_DIV restoring divide
//   i_acc    : product high half (mul) / partial remainder (div)
//   i_quo    : product low half holding remaining multiplier bits (mul) /
//              dividend bits being shifted into the quotient (div)
//   i_opnd   : |multiplicand| (mul) / |divisor| (div)
//   o_acc    : next accumulator / remainder
//   o_quo    : next low half / quotient
module mdu_step
  import mdu_pkg::*;
#(
  parameter int W = MDU_DATA_BITS
) (
  input  mdu_mode_e    i_mode,
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_opnd,
  output logic [W-1:0] o_acc,
  output logic [W-1:0] o_quo
);

  logic [W:0]   w_add;
  logic [W:0]   w_shl;
  logic [W-1:0] w_trial;

  always_comb begin
    w_add   = '0;
    w_shl   = '0;
    w_trial = '0;
    o_acc   = i_acc;
    o_quo   = i_quo;
    if (i_mode == MODE_MUL) begin
      // Carry out of the add is kept and shifted back into the top bit.
      w_add = i_quo[0] ? ({1'b0, i_acc} + {1'b0, i_opnd}) : {1'b0, i_acc};
      o_acc = w_add[W:1];
      o_quo = {w_add[0], i_quo[W-1:1]};
    end else begin
      w_shl   = {i_acc, i_quo[W-1]};
      // The difference always fits in W bits when the subtract is taken,
      // because the remainder stays below the divisor.
      w_trial = w_shl[W-1:0] - i_opnd;
      if (w_shl >= {1'b0, i_opnd}) begin
        o_acc = w_trial;
        o_quo = {i_quo[W-2:0], 1'b1};
      end else begin
        o_acc = w_shl[W-1:0];
        o_quo = {i_quo[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO.
//   clk, rst_n : clock, async active-low reset
//   start, op  : EX presents an MDU instruction (op 0-5, 6-7 ignored)
//   a, b       : rs / rt operands
//   rd_req     : EX instruction reads HI/LO (MFHI/MFLO)
//   flush      : exception/interrupt abort
//   busy       : operation in flight
//   stall      : combinational pipeline freeze request
//   done       : one-cycle pulse after HI/LO updated by MULT/DIV
//   hi, lo     : HI/LO registers
//
// state | meaning
// IDLE  | accepts MDU ops, MTHI/MTLO write directly
// RUN   | one shift-add / restoring-divide iteration per cycle
// FIX   | sign correction and HI/LO write-back
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int DATA_BITS = MDU_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  input  logic                 rd_req,
  input  logic                 flush,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic [DATA_BITS-1:0] hi,
  output logic [DATA_BITS-1:0] lo
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BITS - 1);

  mdu_state_e           r_state;
  mdu_state_e           w_next_state;
  mdu_mode_e            r_mode;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg_res;
  logic                 r_neg_a;
  logic [DATA_BITS-1:0] r_acc;
  logic [DATA_BITS-1:0] r_quo;
  logic [DATA_BITS-1:0] r_opnd;
  logic [DATA_BITS-1:0] r_hi;
  logic [DATA_BITS-1:0] r_lo;
  logic                 r_done;

  logic                 w_idle;
  logic                 w_accept;
  logic                 w_mthi;
  logic                 w_mtlo;
  logic                 w_run_step;
  logic                 w_commit;
  logic                 w_signed;
  logic [DATA_BITS-1:0] w_abs_a;
  logic [DATA_BITS-1:0] w_abs_b;
  logic [DATA_BITS-1:0] w_step_acc;
  logic [DATA_BITS-1:0] w_step_quo;
  logic [2*DATA_BITS-1:0] w_prod;
  logic [DATA_BITS-1:0] w_quo_fix;
  logic [DATA_BITS-1:0] w_rem_fix;

  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_abs_a  = (w_signed && a[DATA_BITS-1]) ? -a : a;
  assign w_abs_b  = (w_signed && b[DATA_BITS-1]) ? -b : b;

  mdu_step #(.W(DATA_BITS)) u_step (
    .i_mode (r_mode),
    .i_acc  (r_acc),
    .i_quo  (r_quo),
    .i_opnd (r_opnd),
    .o_acc  (w_step_acc),
    .o_quo  (w_step_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_idle       = (r_state == ST_IDLE);
    w_accept     = 1'b0;
    w_mthi       = 1'b0;
    w_mtlo       = 1'b0;
    w_run_step   = 1'b0;
    w_commit     = 1'b0;
    // Flush overrides everything, including a start in the same cycle.
    if (flush) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_accept = start && !op[2];
          w_mthi   = start && (op == OP_MTHI);
          w_mtlo   = start && (op == OP_MTLO);
          if (w_accept) w_next_state = ST_RUN;
        end
        ST_RUN: begin
          w_run_step = 1'b1;
          if (r_cnt == LAST_CNT) w_next_state = ST_FIX;
        end
        ST_FIX: begin
          w_commit     = 1'b1;
          w_next_state = ST_IDLE;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  assign busy  = !w_idle;
  assign stall = busy && (rd_req || start);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

  // A zero divisor leaves the dividend magnitude in the remainder, so the
  // remainder sign fix alone restores HI = a; only the quotient is forced.
  assign w_prod    = r_neg_res ? -{r_acc, r_quo} : {r_acc, r_quo};
  assign w_quo_fix = (r_opnd == '0) ? {DATA_BITS{DIV0_LO[0]}} :
                     (r_neg_res ? -r_quo : r_quo);
  assign w_rem_fix = r_neg_a ? -r_acc : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= MODE_MUL;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_a   <= 1'b0;
      r_acc     <= '0;
      r_quo     <= '0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_accept) begin
        r_mode    <= op[1] ? MODE_DIV : MODE_MUL;
        r_cnt     <= '0;
        r_neg_res <= w_signed && (a[DATA_BITS-1] ^ b[DATA_BITS-1]);
        r_neg_a   <= w_signed && a[DATA_BITS-1];
        r_acc     <= '0;
        // Multiply walks |b| out of the low half; divide walks |a| in.
        r_quo     <= op[1] ? w_abs_a : w_abs_b;
        r_opnd    <= op[1] ? w_abs_b : w_abs_a;
      end
      if (w_mthi) r_hi <= a;
      if (w_mtlo) r_lo <= a;
      if (w_run_step) begin
        r_acc <= w_step_acc;
        r_quo <= w_step_quo;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_commit) begin
        if (r_mode == MODE_MUL) begin
          r_hi <= w_prod[2*DATA_BITS-1:DATA_BITS];
          r_lo <= w_prod[DATA_BITS-1:0];
        end else begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end
      end
    end
  end

endmodule
